gru_window_sequencer: RTL and testbench

// Initiator side of the GRU model start/done handshake. Collects a stream of received equalizer samples into a sliding window.

---
 rtl/gru_window_sequencer.sv | 119 +++++++++++
 tb/tb_gru_window_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gru_window_sequencer.sv
// Initiator side of the GRU model start/done handshake: gathers received samples into a
// sliding window, requests one inference per accepted sample once full, and buffers the result.
module gru_window_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int INPUT_FEATURES  = 3,
  parameter int SEQUENCE_LENGTH = 3,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                                                 clk,
  input  logic                                                 rstn,
  input  logic                                                 i_flush,
  input  logic                                                 i_sample_valid,
  input  logic [DATA_WIDTH-1:0]                                i_sample_data,
  output logic                                                 o_sample_ready,
  output logic                                                 o_model_start,
  input  logic                                                 i_model_done,
  input  logic [DATA_WIDTH-1:0]                                i_model_prediction,
  output logic [SEQUENCE_LENGTH*INPUT_FEATURES*DATA_WIDTH-1:0] o_sequence_flat,
  output logic                                                 o_pred_valid,
  output logic [DATA_WIDTH-1:0]                                o_pred_data,
  input  logic                                                 i_pred_ready,
  output logic                                                 o_timeout,
  output logic [15:0]                                          o_infer_count
);

  localparam int WINDOW  = SEQUENCE_LENGTH * INPUT_FEATURES;
  localparam int FLAT_W  = WINDOW * DATA_WIDTH;
  localparam int FILL_W  = $clog2(WINDOW + 1);
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [FILL_W-1:0]  FILL_FULL   = FILL_W'(WINDOW);
  localparam logic [FILL_W-1:0]  FILL_LAST   = FILL_W'(WINDOW - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ACCEPT    = 2'd0,
    WAIT_DONE = 2'd1,
    RELEASE   = 2'd2
  } state_t;

  state_t              state;
  logic [FLAT_W-1:0]   window;
  logic [FLAT_W-1:0]   window_shifted;
  logic [FILL_W-1:0]   fill_cnt;
  logic [TIMER_W-1:0]  timer;
  logic                accept;

  assign o_sample_ready  = (state == ACCEPT) && !o_pred_valid && !i_flush;
  assign accept          = i_sample_valid && o_sample_ready;
  assign o_sequence_flat = window;

  // Oldest sample sits at element 0; the newest enters at the top element.
  always_comb begin
    window_shifted = window >> DATA_WIDTH;
    window_shifted[(WINDOW-1)*DATA_WIDTH +: DATA_WIDTH] = i_sample_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ACCEPT;
      window        <= '0;
      fill_cnt      <= '0;
      timer         <= '0;
      o_model_start <= 1'b0;
      o_pred_valid  <= 1'b0;
      o_pred_data   <= '0;
      o_timeout     <= 1'b0;
      o_infer_count <= '0;
    end else if (i_flush) begin
      // Mid-handshake flushes still go through RELEASE so done is seen low before a new start.
      window        <= '0;
      fill_cnt      <= '0;
      o_pred_valid  <= 1'b0;
      o_model_start <= 1'b0;
      state         <= (state == ACCEPT) ? ACCEPT : RELEASE;
    end else begin
      if (o_pred_valid && i_pred_ready) begin
        o_pred_valid <= 1'b0;
      end
      case (state)
        ACCEPT: begin
          if (accept) begin
            window <= window_shifted;
            if (fill_cnt != FILL_FULL) begin
              fill_cnt <= fill_cnt + 1'b1;
            end
            if (fill_cnt >= FILL_LAST) begin
              state         <= WAIT_DONE;
              o_model_start <= 1'b1;
              timer         <= '0;
            end
          end
        end
        WAIT_DONE: begin
          if (i_model_done) begin
            o_pred_data   <= i_model_prediction;
            o_pred_valid  <= 1'b1;
            o_infer_count <= o_infer_count + 16'd1;
            o_model_start <= 1'b0;
            state         <= RELEASE;
          end else if (timer == TIMER_LAST) begin
            o_timeout     <= 1'b1;
            o_model_start <= 1'b0;
            state         <= RELEASE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RELEASE: begin
          if (!i_model_done) begin
            state <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_gru_window_sequencer.sv
// Self-checking bench for gru_window_sequencer: mock GRU model plus a queue-based window and
// inference-count reference, driven through warm-up, streaming, back-pressure, timeout, flush and reset.
module tb_gru_window_sequencer;

  localparam int DW     = 32;
  localparam int WIN    = 9;
  localparam int FLAT_W = WIN * DW;
  localparam int TOUT   = 4096;

  logic              clk;
  logic              rstn;
  logic              i_flush;
  logic              i_sample_valid;
  logic [DW-1:0]     i_sample_data;
  logic              o_sample_ready;
  logic              o_model_start;
  logic              i_model_done;
  logic [DW-1:0]     i_model_prediction;
  logic [FLAT_W-1:0] o_sequence_flat;
  logic              o_pred_valid;
  logic [DW-1:0]     o_pred_data;
  logic              i_pred_ready;
  logic              o_timeout;
  logic [15:0]       o_infer_count;

  int tests_run    = 0;
  int tests_failed = 0;

  gru_window_sequencer dut (
    .clk                (clk),
    .rstn               (rstn),
    .i_flush            (i_flush),
    .i_sample_valid     (i_sample_valid),
    .i_sample_data      (i_sample_data),
    .o_sample_ready     (o_sample_ready),
    .o_model_start      (o_model_start),
    .i_model_done       (i_model_done),
    .i_model_prediction (i_model_prediction),
    .o_sequence_flat    (o_sequence_flat),
    .o_pred_valid       (o_pred_valid),
    .o_pred_data        (o_pred_data),
    .i_pred_ready       (i_pred_ready),
    .o_timeout          (o_timeout),
    .o_infer_count      (o_infer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mock GRU model: done rises five cycles after start, holds until start drops.
  logic mock_enable;
  int   mock_cnt;
  int   mock_calls;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_model_done       <= 1'b0;
      i_model_prediction <= '0;
      mock_cnt           <= 0;
      mock_calls         <= 0;
    end else if (!o_model_start) begin
      i_model_done <= 1'b0;
      mock_cnt     <= 0;
    end else if (!i_model_done && mock_enable) begin
      if (mock_cnt == 4) begin
        i_model_done       <= 1'b1;
        mock_calls         <= mock_calls + 1;
        i_model_prediction <= 32'hA000_0000 | 32'(mock_calls + 1);
      end else begin
        mock_cnt <= mock_cnt + 1;
      end
    end
  end

  task automatic check_flat(input string tag, input logic [FLAT_W-1:0] obs,
                            input logic [FLAT_W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check_flat(tag, FLAT_W'(obs), FLAT_W'(exp));
  endtask

  task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    check_flat(tag, FLAT_W'(obs), FLAT_W'(exp));
  endtask

  // A start request must never begin while the model still reports done.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (o_model_start && !prev_start) check_bit("start_rise_vs_done", i_model_done, 1'b0);
    prev_start = o_model_start;
  end

  // Reference: the last WIN accepted samples (zeros after reset/flush) and the inference tally.
  logic [DW-1:0] ref_q[$];
  int            ref_fill;
  int            ref_infers;

  function automatic void ref_clear();
    ref_q.delete();
    for (int i = 0; i < WIN; i++) ref_q.push_back('0);
    ref_fill = 0;
  endfunction

  function automatic bit ref_accept(input logic [DW-1:0] d);
    ref_q.push_back(d);
    void'(ref_q.pop_front());
    if (ref_fill < WIN) ref_fill++;
    return (ref_fill == WIN);
  endfunction

  function automatic logic [FLAT_W-1:0] ref_flat();
    logic [FLAT_W-1:0] f = '0;
    for (int k = 0; k < WIN; k++) f[k*DW +: DW] = ref_q[k];
    return f;
  endfunction

  task automatic applyStimulus(input logic [DW-1:0] d, output bit fires);
    int budget = 0;
    @(negedge clk);
    i_sample_valid = 1'b1;
    i_sample_data  = d;
    while (!o_sample_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check_bit("accept_wait", budget < 200, 1'b1);
    @(posedge clk);
    fires = ref_accept(d);
    @(negedge clk);
    i_sample_valid = 1'b0;
  endtask

  task automatic wait_pred(input string tag);
    int budget = 0;
    while (!o_pred_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    ref_infers++;
    check_bit({tag, "_valid"}, o_pred_valid, 1'b1);
    check_word({tag, "_data"}, o_pred_data, 32'hA000_0000 | 32'(ref_infers));
    check_word({tag, "_count"}, 32'(o_infer_count), 32'(ref_infers & 16'hFFFF));
    check_flat({tag, "_window"}, o_sequence_flat, ref_flat());
  endtask

  task automatic checkOutput(input string tag);
    wait_pred(tag);
    i_pred_ready = 1'b1;
    @(negedge clk);
    i_pred_ready = 1'b0;
    check_bit({tag, "_consumed"}, o_pred_valid, 1'b0);
  endtask

  initial begin
    bit            fires;
    int            cnt;
    bit            seen;
    logic [DW-1:0] d2;
    logic [DW-1:0] held;

    rstn = 1'b0; i_flush = 1'b0; i_sample_valid = 1'b0; i_sample_data = '0;
    i_pred_ready = 1'b0; mock_enable = 1'b1;
    ref_clear();
    ref_infers = 0;
    repeat (2) @(negedge clk);
    check_bit("reset_start", o_model_start, 1'b0);
    check_bit("reset_pred_valid", o_pred_valid, 1'b0);
    check_flat("reset_window", o_sequence_flat, '0);
    check_word("reset_count", 32'(o_infer_count), 32'd0);
    check_bit("reset_ready", o_sample_ready, 1'b1);
    rstn = 1'b1;

    // Warm-up: eight samples raise no request, the ninth does.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(DW'(i), fires);
      check_bit("warmup_no_start", o_model_start, 1'b0);
      check_flat("warmup_window", o_sequence_flat, ref_flat());
    end
    applyStimulus(DW'(9), fires);
    check_bit("warmup_fires", fires, 1'b1);
    check_bit("warmup_start", o_model_start, 1'b1);
    check_bit("wait_not_ready", o_sample_ready, 1'b0);
    checkOutput("warmup_pred");

    // Streaming with stride one.
    for (int i = 10; i <= 12; i++) begin
      applyStimulus(DW'(i), fires);
      check_bit("stream_start", o_model_start, 1'b1);
      checkOutput("stream_pred");
    end
    check_word("stream_total", 32'(o_infer_count), 32'd4);

    // Back-pressure: a held prediction blocks sample acceptance and stays stable.
    applyStimulus($urandom, fires);
    wait_pred("bp_pred");
    held = 32'hA000_0000 | 32'(ref_infers);
    d2 = $urandom;
    i_sample_valid = 1'b1;
    i_sample_data  = d2;
    cnt = $urandom_range(3, 8);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      check_bit("bp_ready_low", o_sample_ready, 1'b0);
      check_word("bp_data_stable", o_pred_data, held);
    end
    i_pred_ready = 1'b1;
    @(negedge clk);
    i_pred_ready = 1'b0;
    check_bit("bp_consumed", o_pred_valid, 1'b0);
    check_bit("bp_ready_back", o_sample_ready, 1'b1);
    @(posedge clk);
    fires = ref_accept(d2);
    @(negedge clk);
    i_sample_valid = 1'b0;
    check_bit("bp_sample_start", o_model_start, 1'b1);
    checkOutput("bp_next_pred");

    // Timeout: the model never answers.
    mock_enable = 1'b0;
    applyStimulus($urandom, fires);
    cnt = 0;
    while (o_model_start && cnt < TOUT + 100) begin
      cnt++;
      @(negedge clk);
    end
    check_word("timeout_cycles", 32'(cnt), 32'(TOUT));
    check_bit("timeout_flag", o_timeout, 1'b1);
    check_bit("timeout_no_pred", o_pred_valid, 1'b0);
    check_word("timeout_count", 32'(o_infer_count), 32'(ref_infers));
    mock_enable = 1'b1;
    applyStimulus($urandom, fires);
    checkOutput("after_timeout_pred");
    check_bit("timeout_sticky", o_timeout, 1'b1);

    // Flush during WAIT_DONE discards the request and empties the window.
    applyStimulus($urandom, fires);
    repeat (2) @(negedge clk);
    i_flush = 1'b1;
    #1 check_bit("flush_ready_low", o_sample_ready, 1'b0);
    @(negedge clk);
    i_flush = 1'b0;
    ref_clear();
    check_bit("flush_start", o_model_start, 1'b0);
    check_flat("flush_window", o_sequence_flat, ref_flat());
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_pred_valid) seen = 1'b1;
    end
    check_bit("flush_no_late_pred", seen, 1'b0);
    check_word("flush_count", 32'(o_infer_count), 32'(ref_infers));
    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom, fires);
      check_bit("refill_no_start", o_model_start, 1'b0);
    end
    applyStimulus($urandom, fires);
    check_bit("refill_start", o_model_start, 1'b1);
    checkOutput("refill_pred");

    // Asynchronous reset in the middle of a request.
    applyStimulus($urandom, fires);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_bit("midreset_start", o_model_start, 1'b0);
    check_bit("midreset_pred_valid", o_pred_valid, 1'b0);
    check_bit("midreset_timeout", o_timeout, 1'b0);
    check_flat("midreset_window", o_sequence_flat, '0);
    check_word("midreset_count", 32'(o_infer_count), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    ref_clear();
    ref_infers = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom, fires);
      check_bit("rewarm_no_start", o_model_start, 1'b0);
    end
    applyStimulus($urandom, fires);
    check_bit("rewarm_start", o_model_start, 1'b1);
    checkOutput("rewarm_pred");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
